// File: rtl/mux_sweep_checker.sv
// Exhaustive stimulus sequencer and response checker for the select network z = c ? b : a.
// Walks {a,b,c} through all eight vectors for PASSES sweeps, samples z after SETTLE cycles.
module mux_sweep_checker #(
  parameter int unsigned SETTLE = 1,
  parameter int unsigned PASSES = 1,
  parameter int unsigned ERR_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  output logic             a,
  output logic             b,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [7:0]       fail_vec
);

  localparam int unsigned WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam int unsigned PCNT_W = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(SETTLE - 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PASSES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SAMPLE,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [2:0]         idx_q, idx_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic [ERR_W-1:0]   err_q, err_d;
  logic [7:0]         fv_q, fv_d;
  logic               exp_z;
  logic               mismatch;

  assign exp_z    = idx_q[0] ? idx_q[1] : idx_q[2];
  assign mismatch = (z != exp_z);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      wait_q  <= '0;
      pcnt_q  <= '0;
      err_q   <= '0;
      fv_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      pcnt_q  <= pcnt_d;
      err_q   <= err_d;
      fv_q    <= fv_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    pcnt_d  = pcnt_q;
    err_d   = err_q;
    fv_d    = fv_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_WAIT;
          idx_d   = '0;
          wait_d  = WAIT_LOAD;
          pcnt_d  = '0;
          err_d   = '0;
          fv_d    = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == '0) begin
          state_d = S_SAMPLE;
        end else begin
          wait_d = wait_q - WAIT_W'(1);
        end
      end
      S_SAMPLE: begin
        if (mismatch) begin
          if (err_q != '1) begin
            err_d = err_q + ERR_W'(1);
          end
          fv_d[idx_q] = 1'b1;
        end
        wait_d = WAIT_LOAD;
        if (idx_q != 3'd7) begin
          idx_d   = idx_q + 3'd1;
          state_d = S_WAIT;
        end else if (pcnt_q < PCNT_LAST) begin
          idx_d   = '0;
          pcnt_d  = pcnt_q + PCNT_W'(1);
          state_d = S_WAIT;
        end else begin
          idx_d   = '0;
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status flags decode straight from the state register so reset clears them without a clock.
  assign a         = idx_q[2];
  assign b         = idx_q[1];
  assign c         = idx_q[0];
  assign busy      = (state_q == S_WAIT) || (state_q == S_SAMPLE);
  assign done      = (state_q == S_DONE);
  assign pass      = done && (err_q == '0);
  assign err_count = err_q;
  assign fail_vec  = fv_q;

endmodule

// File: tb/tb_mux_sweep_checker.sv
// Bench for mux_sweep_checker: three instances (defaults, PASSES=40, SETTLE=3) driven by
// selectable downstream models; run outcomes are queued at start and checked when done rises.
module tb_mux_sweep_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [2:0] start_v, z_v, a_v, b_v, c_v, busy_v, done_v, pass_v;
  logic [7:0] err_v [3];
  logic [7:0] fv_v [3];
  int         mode [3];
  logic [2:0] pipe [4];

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int sel;
    int mode;
    int err;
    int fv;
    int pass;
    int lat;
    int hold;
    int poke;
  } vec_t;

  typedef struct {
    int err;
    int fv;
    int pass;
    int lat;
  } exp_t;

  exp_t sb [$];
  vec_t tbl [8];

  function automatic logic gate(input logic ia, input logic ib, input logic ic);
    return (ia & ~ic) | (ic & ib);
  endfunction

  always_comb begin
    z_v = '0;
    case (mode[0])
      1:       z_v[0] = 1'b0;
      2:       z_v[0] = ~gate(a_v[0], b_v[0], c_v[0]);
      default: z_v[0] = gate(a_v[0], b_v[0], c_v[0]);
    endcase
    z_v[1] = ~gate(a_v[1], b_v[1], c_v[1]);
    case (mode[2])
      1:       z_v[2] = gate(pipe[2][2], pipe[2][1], pipe[2][0]);
      2:       z_v[2] = gate(pipe[3][2], pipe[3][1], pipe[3][0]);
      default: z_v[2] = gate(a_v[2], b_v[2], c_v[2]);
    endcase
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= {a_v[2], b_v[2], c_v[2]};
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
      pipe[3] <= pipe[2];
    end
  end

  mux_sweep_checker u0 (
    .clk(clk), .rst_n(rst_n), .start(start_v[0]), .z(z_v[0]),
    .a(a_v[0]), .b(b_v[0]), .c(c_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .pass(pass_v[0]), .err_count(err_v[0]), .fail_vec(fv_v[0])
  );

  mux_sweep_checker #(.SETTLE(1), .PASSES(40), .ERR_W(8)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start_v[1]), .z(z_v[1]),
    .a(a_v[1]), .b(b_v[1]), .c(c_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .pass(pass_v[1]), .err_count(err_v[1]), .fail_vec(fv_v[1])
  );

  mux_sweep_checker #(.SETTLE(3), .PASSES(1), .ERR_W(8)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start_v[2]), .z(z_v[2]),
    .a(a_v[2]), .b(b_v[2]), .c(c_v[2]), .busy(busy_v[2]), .done(done_v[2]),
    .pass(pass_v[2]), .err_count(err_v[2]), .fail_vec(fv_v[2])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_idle(input int s, input string tag);
    chk({tag, "_abc"},  {29'd0, a_v[s], b_v[s], c_v[s]}, 0);
    chk({tag, "_busy"}, {31'd0, busy_v[s]}, 0);
    chk({tag, "_done"}, {31'd0, done_v[s]}, 0);
    chk({tag, "_pass"}, {31'd0, pass_v[s]}, 0);
    chk({tag, "_err"},  {24'd0, err_v[s]}, 0);
    chk({tag, "_fv"},   {24'd0, fv_v[s]}, 0);
  endtask

  task automatic run(input vec_t v);
    int   lat;
    bit   fin;
    exp_t e;
    int   s;
    s = v.sel;
    mode[s] = v.mode;
    sb.push_back('{v.err, v.fv, v.pass, v.lat});
    @(negedge clk);
    start_v[s] = 1'b1;
    @(posedge clk);
    #1 start_v[s] = 1'b0;
    chk("start_busy", {31'd0, busy_v[s]}, 1);
    chk("start_done", {31'd0, done_v[s]}, 0);
    chk("start_err",  {24'd0, err_v[s]}, 0);
    chk("start_fv",   {24'd0, fv_v[s]}, 0);
    if (v.hold > 0) chk("walk", {29'd0, a_v[s], b_v[s], c_v[s]}, 0);
    lat = 0;
    fin = 1'b0;
    for (int k = 1; k <= 2000 && !fin; k++) begin
      if (k == v.poke) start_v[s] = 1'b1;
      @(posedge clk);
      #1 start_v[s] = 1'b0;
      if (done_v[s]) begin
        fin = 1'b1;
        lat = k;
      end else begin
        if (!busy_v[s]) chk("busy_drop", {31'd0, busy_v[s]}, 1);
        if (v.hold > 0) chk("walk", {29'd0, a_v[s], b_v[s], c_v[s]}, (k / v.hold) % 8);
      end
    end
    if (!fin) chk("done_timeout", {31'd0, fin}, 1);
    e = sb.pop_front();
    chk("latency",   lat, e.lat);
    chk("err_count", {24'd0, err_v[s]}, e.err);
    chk("fail_vec",  {24'd0, fv_v[s]}, e.fv);
    chk("pass",      {31'd0, pass_v[s]}, e.pass);
    chk("done_busy", {31'd0, busy_v[s]}, 0);
    chk("done_abc",  {29'd0, a_v[s], b_v[s], c_v[s]}, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("done_hold", {31'd0, done_v[s]}, 1);
    chk("err_hold",  {24'd0, err_v[s]}, e.err);
  endtask

  initial begin
    bit found;
    tbl[0] = '{0, 0, 0,   'h00, 1, 16,  2, -1};
    tbl[1] = '{0, 1, 4,   'hD8, 0, 16,  0,  5};
    tbl[2] = '{0, 0, 0,   'h00, 1, 16,  2, -1};
    tbl[3] = '{0, 2, 8,   'hFF, 0, 16,  0, -1};
    tbl[4] = '{1, 0, 255, 'hFF, 0, 640, 0, -1};
    tbl[5] = '{2, 0, 0,   'h00, 1, 32,  4, -1};
    tbl[6] = '{2, 1, 0,   'h00, 1, 32,  4, -1};
    tbl[7] = '{2, 2, 3,   'h68, 0, 32,  0, -1};

    rst_n   = 1'b0;
    start_v = '0;
    for (int i = 0; i < 3; i++) mode[i] = 0;
    #1;
    for (int i = 0; i < 3; i++) chk_idle(i, "reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) run(tbl[i]);

    mode[0] = 0;
    @(negedge clk);
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    found = 1'b0;
    for (int k = 0; k < 40 && !found; k++) begin
      @(posedge clk);
      #1;
      if ({a_v[0], b_v[0], c_v[0]} == 3'd5) found = 1'b1;
    end
    chk("reach_vec5", {31'd0, found}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk_idle(0, "async_rst");
    @(posedge clk);
    #2 rst_n = 1'b1;
    #1 chk_idle(0, "post_rst");
    run('{0, 0, 0, 'h00, 1, 16, 2, -1});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mux_sweep_checker.md
# mux_sweep_checker

Exhaustive stimulus sequencer and response checker for the 3-input select gate network (z = (a & ~c) | (c & b), i.e. z = c ? b : a). It sits directly upstream of that network, drives a, b, c through all eight combinations, and consumes z back. It compares each response against the expected value, accumulates errors and a per-vector failure map, and reports pass/fail, replacing hand-written initial-block stimulus in lab benches and on-board self-test.

## Interface
- SETTLE, default 1: cycles the vector is held before z is sampled; legal range ≥1.
- PASSES, default 1: number of full 8-vector sweeps per run; legal range ≥1.
- ERR_W, default 8: width of the error counter.

- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- z  in  1  response from the downstream gate network.
- a  out  1  stimulus, registered.
- b  out  1  stimulus, registered.
- c  out  1  stimulus, registered.
- busy  out  1  high while a run is in progress.
- done  out  1  high in DONE; held until the next start or reset.
- pass  out  1  high only when done is high and err_count is 0.
- err_count  out  ERR_W  number of mismatches, saturating at all ones.
- fail_vec  out  8  bit i is set if vector i ({a,b,c}=i) mismatched on any pass.

## Operation
- Vector index idx is 3 bits; outputs a=idx[2], b=idx[1], c=idx[0], driven from registers.
- Expected value: exp = c ? b : a, computed from the registered idx.
- States:
  - IDLE: idx=0; busy=0; done=0. On start: clear err_count, fail_vec and the pass counter pcnt, load the wait counter, go to WAIT.
  - WAIT: hold idx for SETTLE cycles, then go to SAMPLE.
  - SAMPLE: compare z with exp. On mismatch, increment err_count (saturating) and set fail_vec[idx].
    - If idx≠7: idx++, then WAIT.
    - If idx=7 and pcnt<PASSES-1: idx=0, pcnt++, then WAIT.
    - Otherwise: go to DONE with idx=0.
  - DONE: done=1, busy=0. err_count and fail_vec hold. start restarts the run exactly as from IDLE.
- busy=1 in WAIT and SAMPLE. start is ignored there.
- pcnt is sized to hold PASSES-1.

## Timing
- Reset (asynchronous, any state, including mid-sweep):
  - state goes to IDLE;
  - a=b=c=0, busy=0, done=0, pass=0, err_count=0, fail_vec=0.
- Edge E0 accepts start. busy is high after E0.
- Each vector occupies SETTLE+1 cycles. z is sampled at the edge that leaves SAMPLE, i.e. SETTLE full cycles after idx changed.
- done rises after edge E0 + 8·PASSES·(SETTLE+1). For the defaults that is 16 cycles.
- The done cycle and the falling of busy coincide. a, b, c return to 0 on the same edge.
- Restart from DONE: done drops on the edge that accepts start, and the counters clear on that same edge.
- z must be a function of the current a, b, c within SETTLE cycles. A z that changes inside the settle window is not checked.
- Saturation: once err_count reaches 2^ERR_W-1 it holds. fail_vec continues to update.

## Test plan
- **Correct downstream model, defaults.** Pulse start. Required: busy for 16 cycles, then done=1, pass=1, err_count=0, fail_vec=8'h00, and a,b,c walk 000→111 with each value held 2 cycles.
- **z stuck at 0.** Required: err_count=4, fail_vec=8'hD8 (vectors 3, 4, 6, 7), pass=0.
- **z = ~(c ? b : a), PASSES=40, ERR_W=8.** Required: fail_vec=8'hFF and err_count saturates at 255, not 320. done arrives 640 cycles after start.
- **SETTLE=3, correct model.** Required: each vector held 4 cycles and done after 32 cycles. Separately, delaying z by 3 cycles still gives pass=1; delaying it by 4 gives failures.
- **rst_n low for 1 cycle at vector 5 mid-sweep.** Required: all outputs are 0 immediately, without waiting for a clock edge. A following start runs a full clean sweep with pass=1.
- **start pulsed during busy, then again in DONE.** Required: the first pulse has no effect on timing or counts. The second pulse clears done, err_count and fail_vec on its edge and reruns.
